// File: rtl/remote_comm_pkg.sv
// Shared types and constants for the remote_comm host-side command initiator.
// The optional response timeout is enabled by defining RESP_TIMEOUT_EN.
package remote_comm_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      SEND_CMD  = 3'd1,
      SEND_HIGH = 3'd2,
      SEND_LOW  = 3'd3,
      WAIT_RESP = 3'd4
   } state_t;

   localparam int unsigned CMD_BYTES = 3;
   localparam int unsigned SHADOW_W  = 8 * CMD_BYTES;

   localparam int unsigned BYTE_CMD  = 0;
   localparam int unsigned BYTE_HIGH = 1;
   localparam int unsigned BYTE_LOW  = 2;

   // Byte 0 is the most significant byte of the shadow (first on the wire).
   function automatic logic [7:0] shadow_byte(input logic [SHADOW_W-1:0] shadow,
                                              input int unsigned idx);
      shadow_byte = shadow[SHADOW_W - 8 - 8 * idx +: 8];
   endfunction

endpackage

// File: rtl/remote_comm_uart.sv
// 8N1 UART transceiver: tx_done is a level set at the end of the stop bit and
// cleared by trmt; rx_rdy is set on each received byte and cleared by clr_rx_rdy.
module remote_comm_uart #(
   parameter int unsigned BAUD_DIV = 2604
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       trmt_i,
   input  logic [7:0] tx_data_i,
   output logic       tx_o,
   output logic       tx_done_o,
   input  logic       rx_i,
   input  logic       clr_rx_rdy_i,
   output logic [7:0] rx_data_o,
   output logic       rx_rdy_o
);

   localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);
   localparam logic [15:0] BAUD_HALF = 16'(BAUD_DIV / 2);

   logic [9:0]  tx_shift_q, tx_shift_d;
   logic [15:0] tx_baud_q, tx_baud_d;
   logic [3:0]  tx_bits_q, tx_bits_d;
   logic        tx_busy_q, tx_busy_d;
   logic        tx_done_q, tx_done_d;

   logic        rx_meta_q, rx_sync_q;
   logic [7:0]  rx_shift_q, rx_shift_d;
   logic [15:0] rx_baud_q, rx_baud_d;
   logic [3:0]  rx_bits_q, rx_bits_d;
   logic        rx_busy_q, rx_busy_d;
   logic [7:0]  rx_data_q, rx_data_d;
   logic        rx_rdy_q, rx_rdy_d;
   logic        rx_done_s;

   // Transmit shifter: {stop, data, start} shifted out LSB first, refilled with idle ones.
   always_comb begin
      tx_shift_d = tx_shift_q;
      tx_baud_d  = tx_baud_q;
      tx_bits_d  = tx_bits_q;
      tx_busy_d  = tx_busy_q;
      tx_done_d  = tx_done_q;
      if (trmt_i) begin
         tx_shift_d = {1'b1, tx_data_i, 1'b0};
         tx_baud_d  = 16'd0;
         tx_bits_d  = 4'd0;
         tx_busy_d  = 1'b1;
         tx_done_d  = 1'b0;
      end else if (tx_busy_q) begin
         if (tx_baud_q == BAUD_LAST) begin
            tx_baud_d  = 16'd0;
            tx_shift_d = {1'b1, tx_shift_q[9:1]};
            if (tx_bits_q == 4'd9) begin
               tx_bits_d = 4'd0;
               tx_busy_d = 1'b0;
               tx_done_d = 1'b1;
            end else begin
               tx_bits_d = tx_bits_q + 4'd1;
            end
         end else begin
            tx_baud_d = tx_baud_q + 16'd1;
         end
      end else begin
         tx_busy_d = 1'b0;
      end
   end

   // Receiver: sample each bit at its centre; a start bit that is high at mid-bit is a glitch.
   always_comb begin
      rx_shift_d = rx_shift_q;
      rx_baud_d  = rx_baud_q;
      rx_bits_d  = rx_bits_q;
      rx_busy_d  = rx_busy_q;
      rx_data_d  = rx_data_q;
      rx_done_s  = 1'b0;
      if (!rx_busy_q) begin
         if (!rx_sync_q) begin
            rx_busy_d = 1'b1;
            rx_baud_d = BAUD_HALF;
            rx_bits_d = 4'd0;
         end else begin
            rx_busy_d = 1'b0;
         end
      end else if (rx_baud_q == BAUD_LAST) begin
         rx_baud_d = 16'd0;
         if (rx_bits_q == 4'd0) begin
            if (rx_sync_q) begin
               rx_busy_d = 1'b0;
            end else begin
               rx_bits_d = 4'd1;
            end
         end else if (rx_bits_q == 4'd9) begin
            rx_busy_d = 1'b0;
            rx_data_d = rx_shift_q;
            rx_done_s = 1'b1;
         end else begin
            rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
            rx_bits_d  = rx_bits_q + 4'd1;
         end
      end else begin
         rx_baud_d = rx_baud_q + 16'd1;
      end
      if (rx_done_s) begin
         rx_rdy_d = 1'b1;
      end else if (clr_rx_rdy_i) begin
         rx_rdy_d = 1'b0;
      end else begin
         rx_rdy_d = rx_rdy_q;
      end
   end

   // State registers; TX idles high straight out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_shift_q <= 10'h3FF;
         tx_baud_q  <= 16'd0;
         tx_bits_q  <= 4'd0;
         tx_busy_q  <= 1'b0;
         tx_done_q  <= 1'b0;
         rx_meta_q  <= 1'b1;
         rx_sync_q  <= 1'b1;
         rx_shift_q <= 8'd0;
         rx_baud_q  <= 16'd0;
         rx_bits_q  <= 4'd0;
         rx_busy_q  <= 1'b0;
         rx_data_q  <= 8'd0;
         rx_rdy_q   <= 1'b0;
      end else begin
         tx_shift_q <= tx_shift_d;
         tx_baud_q  <= tx_baud_d;
         tx_bits_q  <= tx_bits_d;
         tx_busy_q  <= tx_busy_d;
         tx_done_q  <= tx_done_d;
         rx_meta_q  <= rx_i;
         rx_sync_q  <= rx_meta_q;
         rx_shift_q <= rx_shift_d;
         rx_baud_q  <= rx_baud_d;
         rx_bits_q  <= rx_bits_d;
         rx_busy_q  <= rx_busy_d;
         rx_data_q  <= rx_data_d;
         rx_rdy_q   <= rx_rdy_d;
      end
   end

   assign tx_o      = tx_shift_q[0];
   assign tx_done_o = tx_done_q;
   assign rx_data_o = rx_data_q;
   assign rx_rdy_o  = rx_rdy_q;

endmodule

// File: rtl/remote_comm.sv
// Host-side initiator: sends {cmd, data[15:8], data[7:0]} over UART and returns the response byte.
// Defining RESP_TIMEOUT_EN adds WAIT_RESP, a response timeout counter and the resp_timeout port.
module remote_comm
   import remote_comm_pkg::*;
#(
   parameter int unsigned BAUD_DIV = 2604
`ifdef RESP_TIMEOUT_EN
   , parameter int unsigned TIMEOUT_CYCLES = 1_000_000
`endif
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        RX,
   output logic        TX,
   input  logic        snd_cmd,
   input  logic [7:0]  cmd,
   input  logic [15:0] data,
   input  logic        clr_resp_rdy,
   output logic        cmd_sent,
   output logic        resp_rdy,
   output logic [7:0]  resp
`ifdef RESP_TIMEOUT_EN
   , output logic      resp_timeout
`endif
);

   state_t              state_q, state_d;
   logic [SHADOW_W-1:0] shadow_q, shadow_d;
   logic                trmt_q, trmt_d;
   logic                cmd_sent_q, cmd_sent_d;
   logic                done_ff1_q, done_ff2_q;
   logic                tx_done_s, done_rise_s, accept_s, clr_rx_s, rx_rdy_s;
   logic [7:0]          tx_data_s, rx_data_s;
`ifdef RESP_TIMEOUT_EN
   logic [19:0]         tmo_cnt_q, tmo_cnt_d;
   logic                tmo_q, tmo_d;
`endif

   assign accept_s    = snd_cmd && (state_q == IDLE);
   assign done_rise_s = done_ff1_q && !done_ff2_q;
   assign clr_rx_s    = clr_resp_rdy || accept_s;

   // Byte mux: the byte presented to the UART follows the state that issues its trmt.
   always_comb begin
      case (state_q)
         SEND_HIGH: tx_data_s = shadow_byte(shadow_q, BYTE_HIGH);
         SEND_LOW:  tx_data_s = shadow_byte(shadow_q, BYTE_LOW);
         default:   tx_data_s = shadow_byte(shadow_q, BYTE_CMD);
      endcase
   end

   // Next-state logic, trmt pulses and the cmd_sent set/clear.
   always_comb begin
      state_d    = state_q;
      shadow_d   = shadow_q;
      trmt_d     = 1'b0;
      cmd_sent_d = cmd_sent_q;
`ifdef RESP_TIMEOUT_EN
      tmo_cnt_d  = tmo_cnt_q;
      tmo_d      = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (snd_cmd) begin
               shadow_d   = {cmd, data};
               trmt_d     = 1'b1;
               cmd_sent_d = 1'b0;
               state_d    = SEND_CMD;
            end else begin
               state_d = IDLE;
            end
         end
         SEND_CMD: begin
            if (done_rise_s) begin
               trmt_d  = 1'b1;
               state_d = SEND_HIGH;
            end else begin
               state_d = SEND_CMD;
            end
         end
         SEND_HIGH: begin
            if (done_rise_s) begin
               trmt_d  = 1'b1;
               state_d = SEND_LOW;
            end else begin
               state_d = SEND_HIGH;
            end
         end
         SEND_LOW: begin
            if (done_rise_s) begin
               cmd_sent_d = 1'b1;
`ifdef RESP_TIMEOUT_EN
               tmo_cnt_d  = 20'd0;
               state_d    = WAIT_RESP;
`else
               state_d    = IDLE;
`endif
            end else begin
               state_d = SEND_LOW;
            end
         end
         WAIT_RESP: begin
`ifdef RESP_TIMEOUT_EN
            // rx_rdy was cleared at accept, so any set flag here is this command's reply.
            if (rx_rdy_s) begin
               tmo_cnt_d = 20'd0;
               state_d   = IDLE;
            end else if (tmo_cnt_q == 20'(TIMEOUT_CYCLES - 1)) begin
               tmo_cnt_d = 20'd0;
               tmo_d     = 1'b1;
               state_d   = IDLE;
            end else begin
               tmo_cnt_d = tmo_cnt_q + 20'd1;
            end
`else
            state_d = IDLE;
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   // State, shadow, trmt and tx_done edge-detect registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         shadow_q   <= '0;
         trmt_q     <= 1'b0;
         cmd_sent_q <= 1'b0;
         done_ff1_q <= 1'b0;
         done_ff2_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         shadow_q   <= shadow_d;
         trmt_q     <= trmt_d;
         cmd_sent_q <= cmd_sent_d;
         done_ff1_q <= tx_done_s;
         done_ff2_q <= done_ff1_q;
      end
   end

`ifdef RESP_TIMEOUT_EN
   // Response timeout counter and its one-cycle pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tmo_cnt_q <= 20'd0;
         tmo_q     <= 1'b0;
      end else begin
         tmo_cnt_q <= tmo_cnt_d;
         tmo_q     <= tmo_d;
      end
   end

   assign resp_timeout = tmo_q;
`endif

   remote_comm_uart #(
      .BAUD_DIV(BAUD_DIV)
   ) u_uart (
      .clk         (clk),
      .rst_n       (rst_n),
      .trmt_i      (trmt_q),
      .tx_data_i   (tx_data_s),
      .tx_o        (TX),
      .tx_done_o   (tx_done_s),
      .rx_i        (RX),
      .clr_rx_rdy_i(clr_rx_s),
      .rx_data_o   (rx_data_s),
      .rx_rdy_o    (rx_rdy_s)
   );

   assign cmd_sent = cmd_sent_q;
   assign resp_rdy = rx_rdy_s;
   assign resp     = rx_data_s;

endmodule

// File: tb/tb_remote_comm.sv
// Self-checking bench for remote_comm: a bit-level TX decoder and RX responder act as the far end.
// Builds with or without RESP_TIMEOUT_EN.
module tb_remote_comm;

   localparam int BAUD  = 16;
   localparam int FRAME = 10 * BAUD;
`ifdef RESP_TIMEOUT_EN
   localparam int TMO    = 1000;
   localparam int SETTLE = TMO + 20;
`else
   localparam int SETTLE = 2;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        RX = 1'b1;
   logic        TX;
   logic        snd_cmd = 1'b0;
   logic [7:0]  cmd = 8'd0;
   logic [15:0] data = 16'd0;
   logic        clr_resp_rdy = 1'b0;
   logic        cmd_sent;
   logic        resp_rdy;
   logic [7:0]  resp;
`ifdef RESP_TIMEOUT_EN
   logic        resp_timeout;
`endif

   int     tests = 0;
   int     fails = 0;
   longint cyc = 0;

   logic [7:0] mon_bytes[$];
   longint     mon_start[$];
   bit         mon_cs[$];

   remote_comm #(
      .BAUD_DIV(BAUD)
`ifdef RESP_TIMEOUT_EN
      , .TIMEOUT_CYCLES(TMO)
`endif
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .RX          (RX),
      .TX          (TX),
      .snd_cmd     (snd_cmd),
      .cmd         (cmd),
      .data        (data),
      .clr_resp_rdy(clr_resp_rdy),
      .cmd_sent    (cmd_sent),
      .resp_rdy    (resp_rdy),
      .resp        (resp)
`ifdef RESP_TIMEOUT_EN
      , .resp_timeout(resp_timeout)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Far-end receiver: decodes 8N1 frames on TX, drops frames disturbed by reset.
   initial begin : tx_monitor
      logic [7:0] b;
      bit         ok;
      bit         cs;
      longint     st;
      forever begin
         @(negedge TX);
         st = cyc;
         ok = (rst_n === 1'b1);
         for (int i = 0; i < BAUD / 2; i++) begin @(posedge clk); if (!rst_n) ok = 0; end
         if (TX !== 1'b0) ok = 0;
         for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < BAUD; i++) begin @(posedge clk); if (!rst_n) ok = 0; end
            b[k] = TX;
         end
         for (int i = 0; i < BAUD; i++) begin @(posedge clk); if (!rst_n) ok = 0; end
         cs = cmd_sent;
         if (TX !== 1'b1) ok = 0;
         if (ok) begin
            mon_bytes.push_back(b);
            mon_start.push_back(st);
            mon_cs.push_back(cs);
         end
      end
   end

   initial begin : watchdog
      #800_000;
      $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
      $fatal(1, "watchdog expired");
   end

   task automatic clear_mon();
      mon_bytes.delete();
      mon_start.delete();
      mon_cs.delete();
   endtask

   task automatic issue(input logic [7:0] c, input logic [15:0] d);
      @(negedge clk);
      cmd = c; data = d; snd_cmd = 1'b1;
      @(negedge clk);
      snd_cmd = 1'b0;
      cmd = 8'($urandom); data = 16'($urandom);
   endtask

   task automatic wait_sent(output bit ok);
      ok = 0;
      for (int i = 0; i < 3 * (FRAME + 3) + 64; i++) begin
         @(negedge clk);
         if (cmd_sent === 1'b1) begin ok = 1; break; end
      end
   endtask

   task automatic wait_idle_mon(input int n, output bit ok);
      ok = 0;
      for (int i = 0; i < 2 * FRAME; i++) begin
         @(negedge clk);
         if (mon_bytes.size() >= n) begin ok = 1; break; end
      end
   endtask

   task automatic send_rx(input logic [7:0] b);
      @(negedge clk);
      RX = 1'b0;
      repeat (BAUD) @(negedge clk);
      for (int k = 0; k < 8; k++) begin RX = b[k]; repeat (BAUD) @(negedge clk); end
      RX = 1'b1;
      repeat (BAUD) @(negedge clk);
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      tests++; if (TX !== 1'b1) begin fails++; $display("FAIL reset_tx: got %b expected 1", TX); end
      tests++; if (cmd_sent !== 1'b0) begin fails++; $display("FAIL reset_cmd_sent: got %b expected 0", cmd_sent); end
      tests++; if (resp_rdy !== 1'b0) begin fails++; $display("FAIL reset_resp_rdy: got %b expected 0", resp_rdy); end
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   // Random commands (first one the reference 0x02/0xA5C3); inputs scrambled right after accept.
   task automatic test_send();
      logic [7:0]  c;
      logic [15:0] d;
      logic [7:0]  exp_b[3];
      bit          ok;
      for (int n = 0; n < 6; n++) begin
         c = (n == 0) ? 8'h02 : 8'($urandom);
         d = (n == 0) ? 16'hA5C3 : 16'($urandom);
         exp_b[0] = c;
         exp_b[1] = 8'(d / 256);
         exp_b[2] = 8'(d % 256);
         clear_mon();
         issue(c, d);
         wait_sent(ok);
         tests++; if (!ok) begin fails++; $display("FAIL send_done[%0d]: cmd_sent=%b expected 1", n, cmd_sent); end
         repeat (4) @(negedge clk);
         tests++;
         if (mon_bytes.size() != 3) begin
            fails++; $display("FAIL send_frames[%0d]: got %0d frames expected 3", n, mon_bytes.size());
         end else begin
            for (int j = 0; j < 3; j++) begin
               tests++;
               if (mon_bytes[j] !== exp_b[j]) begin
                  fails++; $display("FAIL send_byte[%0d][%0d]: got %h expected %h", n, j, mon_bytes[j], exp_b[j]);
               end
            end
            for (int j = 0; j < 2; j++) begin
               tests++;
               if (mon_start[j+1] - mon_start[j] < FRAME || mon_start[j+1] - mon_start[j] > FRAME + 3) begin
                  fails++; $display("FAIL send_gap[%0d][%0d]: got %0d cycles expected %0d..%0d",
                                    n, j, mon_start[j+1] - mon_start[j], FRAME, FRAME + 3);
               end
            end
            tests++;
            if (mon_cs[2] !== 1'b0) begin
               fails++; $display("FAIL send_early_cmd_sent[%0d]: got %b at 3rd stop bit expected 0", n, mon_cs[2]);
            end
         end
         repeat (SETTLE) @(negedge clk);
      end
   endtask

   task automatic test_ignore();
      logic [7:0]  c;
      logic [15:0] d;
      bit          ok;
      c = 8'($urandom_range(0, 255));
      d = 16'($urandom);
      clear_mon();
      issue(c, d);
      wait_idle_mon(1, ok);
      repeat (3 * BAUD) @(negedge clk);
      cmd = 8'h55; data = 16'($urandom); snd_cmd = 1'b1;
      @(negedge clk);
      snd_cmd = 1'b0;
      wait_sent(ok);
      repeat (2 * FRAME) @(negedge clk);
      tests++; if (!ok || cmd_sent !== 1'b1) begin fails++; $display("FAIL ignore_cmd_sent: got %b expected 1", cmd_sent); end
      tests++;
      if (mon_bytes.size() != 3) begin
         fails++; $display("FAIL ignore_frames: got %0d frames expected 3", mon_bytes.size());
      end else begin
         tests++;
         if (mon_bytes[0] !== c || mon_bytes[1] !== 8'(d / 256) || mon_bytes[2] !== 8'(d % 256)) begin
            fails++; $display("FAIL ignore_bytes: got %h %h %h expected %h %h %h", mon_bytes[0], mon_bytes[1],
                              mon_bytes[2], c, 8'(d / 256), 8'(d % 256));
         end
      end
      repeat (SETTLE) @(negedge clk);
   endtask

   task automatic test_response();
      logic [7:0] b1, b2, b3;
      bit         ok, seen;
      b1 = 8'h0A;
      send_rx(b1);
      ok = 0;
      for (int i = 0; i < 4 * BAUD; i++) begin if (resp_rdy === 1'b1) begin ok = 1; break; end @(negedge clk); end
      tests++; if (!ok) begin fails++; $display("FAIL resp_rdy_set: got %b expected 1", resp_rdy); end
      tests++; if (resp !== b1) begin fails++; $display("FAIL resp_value: got %h expected %h", resp, b1); end
      clr_resp_rdy = 1'b1;
      @(negedge clk);
      clr_resp_rdy = 1'b0;
      tests++; if (resp_rdy !== 1'b0) begin fails++; $display("FAIL resp_clr: got %b expected 0", resp_rdy); end
      b2 = 8'($urandom); b3 = 8'($urandom);
      send_rx(b2);
      send_rx(b3);
      repeat (4) @(negedge clk);
      tests++; if (resp !== b3 || resp_rdy !== 1'b1) begin
         fails++; $display("FAIL resp_overwrite: got %h/%b expected %h/1", resp, resp_rdy, b3);
      end
      // Accept alone clears resp_rdy; a reply that arrives mid-command is still captured.
      @(negedge clk);
      cmd = 8'($urandom); data = 16'($urandom); snd_cmd = 1'b1;
      @(negedge clk);
      snd_cmd = 1'b0;
      tests++; if (resp_rdy !== 1'b0 || cmd_sent !== 1'b0) begin
         fails++; $display("FAIL accept_clears: got resp_rdy=%b cmd_sent=%b expected 0/0", resp_rdy, cmd_sent);
      end
      b1 = 8'($urandom);
      send_rx(b1);
      repeat (4) @(negedge clk);
      tests++; if (resp !== b1 || resp_rdy !== 1'b1) begin
         fails++; $display("FAIL resp_while_sending: got %h/%b expected %h/1", resp, resp_rdy, b1);
      end
      wait_sent(ok);
      repeat (SETTLE) @(negedge clk);
      // snd_cmd accept together with clr_resp_rdy.
      cmd = 8'($urandom); data = 16'($urandom); snd_cmd = 1'b1; clr_resp_rdy = 1'b1;
      @(negedge clk);
      snd_cmd = 1'b0; clr_resp_rdy = 1'b0;
      tests++; if (resp_rdy !== 1'b0) begin fails++; $display("FAIL accept_and_clr: got %b expected 0", resp_rdy); end
      wait_sent(ok);
      repeat (SETTLE) @(negedge clk);
      // Arrival while clr_resp_rdy is held high must still raise resp_rdy for a cycle.
      b2 = 8'($urandom);
      seen = 0;
      clr_resp_rdy = 1'b1;
      fork
         send_rx(b2);
         for (int i = 0; i < FRAME + 2 * BAUD; i++) begin @(negedge clk); if (resp_rdy === 1'b1) seen = 1; end
      join
      clr_resp_rdy = 1'b0;
      @(negedge clk);
      tests++; if (!seen) begin fails++; $display("FAIL arrival_wins: resp_rdy never 1 expected 1"); end
      tests++; if (resp !== b2 || resp_rdy !== 1'b0) begin
         fails++; $display("FAIL arrival_then_clr: got %h/%b expected %h/0", resp, resp_rdy, b2);
      end
      clear_mon();
   endtask

   task automatic test_reset_mid();
      logic [7:0]  c;
      logic [15:0] d;
      bit          ok;
      clear_mon();
      issue(8'($urandom), 16'h00FF);
      wait_idle_mon(1, ok);
      repeat (3 * BAUD) @(negedge clk);
      tests++; if (TX !== 1'b0) begin fails++; $display("FAIL midframe_tx_low: got %b expected 0", TX); end
      rst_n = 1'b0;
      #1;
      tests++; if (TX !== 1'b1) begin fails++; $display("FAIL reset_tx_immediate: got %b expected 1", TX); end
      tests++; if (cmd_sent !== 1'b0) begin fails++; $display("FAIL reset_mid_cmd_sent: got %b expected 0", cmd_sent); end
      repeat (3 * BAUD) @(negedge clk);
      rst_n = 1'b1;
      repeat (FRAME + 40) @(negedge clk);
      tests++; if (cmd_sent !== 1'b0 || mon_bytes.size() != 1) begin
         fails++; $display("FAIL reset_abandon: got cmd_sent=%b frames=%0d expected 0/1", cmd_sent, mon_bytes.size());
      end
      clear_mon();
      c = 8'($urandom); d = 16'($urandom);
      issue(c, d);
      wait_sent(ok);
      repeat (4) @(negedge clk);
      tests++;
      if (!ok || mon_bytes.size() != 3) begin
         fails++; $display("FAIL after_reset_frames: got %0d frames cmd_sent=%b expected 3/1", mon_bytes.size(), cmd_sent);
      end else begin
         tests++;
         if (mon_bytes[0] !== c || mon_bytes[1] !== 8'(d / 256) || mon_bytes[2] !== 8'(d % 256)) begin
            fails++; $display("FAIL after_reset_bytes: got %h %h %h expected %h %h %h", mon_bytes[0], mon_bytes[1],
                              mon_bytes[2], c, 8'(d / 256), 8'(d % 256));
         end
      end
      repeat (SETTLE) @(negedge clk);
   endtask

`ifdef RESP_TIMEOUT_EN
   task automatic test_timeout();
      bit ok, seen;
      int n;
      issue(8'($urandom), 16'($urandom));
      wait_sent(ok);
      n = 0; seen = 0;
      for (int i = 0; i < TMO + 100; i++) begin
         @(negedge clk); n++;
         if (resp_timeout === 1'b1) begin seen = 1; break; end
      end
      tests++; if (!seen || n < TMO - 5 || n > TMO + 5) begin
         fails++; $display("FAIL timeout_pulse: got seen=%b after %0d cycles expected about %0d", seen, n, TMO);
      end
      @(negedge clk);
      tests++; if (resp_timeout !== 1'b0) begin fails++; $display("FAIL timeout_width: got %b expected 0", resp_timeout); end
      issue(8'($urandom), 16'($urandom));
      wait_sent(ok);
      seen = 0;
      fork
         begin repeat (TMO / 2 - FRAME) @(negedge clk); send_rx(8'($urandom)); end
         for (int i = 0; i < TMO + 200; i++) begin @(negedge clk); if (resp_timeout === 1'b1) seen = 1; end
      join
      tests++; if (seen) begin fails++; $display("FAIL timeout_suppressed: got pulse expected none"); end
      clear_mon();
   endtask
`endif

   initial begin
      test_reset();
      test_send();
      test_ignore();
      test_response();
      test_reset_mid();
`ifdef RESP_TIMEOUT_EN
      test_timeout();
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
